// File: rtl/format_class_decode_pipe.sv
// format_class_decode_pipe
// Multi-lane instruction format class decoder with a two-entry skid buffer
// on a valid/ready output handshake. Lane k occupies slice k counted from
// the MSB end of every packed bus (lane 0 is the most significant slice).
// Optional build macro: FMT_REFINE_EN enables second-level refinement of
// primary opcodes 31 (X/XFX/XO) and 19 (DX/XL).
module format_class_decode_pipe #(
    parameter int instructionWidth = 32,
    parameter int addressSize      = 64,
    parameter int opcodeWidth      = 6,
    parameter int formatIndexRange = 5,
    parameter int laneCount        = 2,
    parameter int countWidth       = 16
) (
    input  logic                                             clock_i,
    input  logic                                             reset_ni,
    input  logic                                             flush_i,
    input  logic                                             valid_i,
    output logic                                             ready_o,
    input  logic [laneCount-1:0]                             laneValid_i,
    input  logic [laneCount*instructionWidth-1:0]            instruction_i,
    input  logic [addressSize-1:0]                           address_i,
    output logic                                             valid_o,
    input  logic                                             ready_i,
    output logic [laneCount-1:0]                             laneValid_o,
    output logic [laneCount*opcodeWidth-1:0]                 opCode_o,
    output logic [laneCount*(instructionWidth-opcodeWidth)-1:0] payload_o,
    output logic [laneCount*addressSize-1:0]                 address_o,
    output logic [laneCount*formatIndexRange-1:0]            instructionFormatClass_o,
    output logic [countWidth-1:0]                            invalidCount_o
);

    localparam int W  = instructionWidth;
    localparam int A  = addressSize;
    localparam int O  = opcodeWidth;
    localparam int F  = formatIndexRange;
    localparam int L  = laneCount;
    localparam int CW = countWidth;
    localparam int P  = W - O;
    // Stored entry layout, MSB to LSB: lane valids, raw instructions, lane addresses, classes
    localparam int ENTRY_W = L + L*W + L*A + L*F;

    localparam logic [F-1:0] CLS_INVALID = F'(0);
    localparam logic [F-1:0] CLS_D       = F'(3);
    localparam logic [F-1:0] CLS_DQ      = F'(4);
    localparam logic [F-1:0] CLS_DS      = F'(5);
    localparam logic [F-1:0] CLS_DX      = F'(6);
    localparam logic [F-1:0] CLS_M       = F'(8);
    localparam logic [F-1:0] CLS_MD      = F'(9);
    localparam logic [F-1:0] CLS_VA      = F'(12);
    localparam logic [F-1:0] CLS_X       = F'(15);
`ifdef FMT_REFINE_EN
    localparam logic [F-1:0] CLS_XFX     = F'(17);
    localparam logic [F-1:0] CLS_XL      = F'(18);
    localparam logic [F-1:0] CLS_XO      = F'(19);
`endif

    localparam logic [CW+3:0] CNT_SAT = {4'b0, {CW{1'b1}}};

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    // Instruction bit b (MSB-0 numbering) lives at index W-1-b
    function automatic logic [F-1:0] classify(input logic [W-1:0] ins);
        int unsigned  op;
        logic [F-1:0] cls;
`ifdef FMT_REFINE_EN
        int unsigned  xo10;
        int unsigned  xo9;
        int unsigned  xo5;
        xo10 = int'(ins[W-22 -: 10]);
        xo9  = int'(ins[W-23 -: 9]);
        xo5  = int'(ins[W-27 -: 5]);
`endif
        op  = int'(ins[W-1 -: O]);
        cls = CLS_INVALID;
        case (op) inside
            2, 3, 7, 8, [10:15], [24:29], [32:47]: cls = CLS_D;
            58, 62:                                cls = CLS_DS;
            56:                                    cls = CLS_DQ;
            30:                                    cls = CLS_MD;
            20, 21, 23:                            cls = CLS_M;
            4:                                     cls = CLS_VA;
`ifdef FMT_REFINE_EN
            19: cls = (xo5 == 2) ? CLS_DX : CLS_XL;
            31: begin
                if (xo10 == 339 || xo10 == 467)
                    cls = CLS_XFX;
                else if (xo9 inside {8, 10, 40, 104, 136, 138, 200, 202, 232,
                                     234, 235, 266, 457, 459, 489, 491})
                    cls = CLS_XO;
                else
                    cls = CLS_X;
            end
`else
            19: cls = CLS_DX;
            31: cls = CLS_X;
`endif
            default: cls = CLS_INVALID;
        endcase
        return cls;
    endfunction

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic [ENTRY_W-1:0] out_q, out_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [ENTRY_W-1:0] in_entry;
    logic [L*A-1:0]     in_addr;
    logic [L*F-1:0]     in_cls;
    logic [CW+3:0]      n_inv;
    logic [CW+3:0]      cnt_sum;
    logic               lane_inv;
    logic               accept;
    logic               xfer;

    // Decode the incoming bundle: per-lane addresses, classes and INVALID-lane tally
    always_comb begin
        in_addr  = '0;
        in_cls   = '0;
        n_inv    = '0;
        lane_inv = 1'b0;
        for (int unsigned k = 0; k < L; k++) begin
            in_addr[(L-1-k)*A +: A] = address_i + A'(4*k);
            in_cls[(L-1-k)*F +: F]  = classify(instruction_i[(L-1-k)*W +: W]);
            lane_inv = laneValid_i[L-1-k] && (in_cls[(L-1-k)*F +: F] == CLS_INVALID);
            n_inv    = n_inv + {{(CW+3){1'b0}}, lane_inv};
        end
        in_entry = {laneValid_i, instruction_i, in_addr, in_cls};
    end

    // Skid-buffer next state, entry moves and saturating INVALID counter
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        accept  = valid_i & ready_q;
        xfer    = valid_q & ready_i;
        cnt_sum = {4'b0, cnt_q} + n_inv;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    state_d = ST_ONE;
                    out_d   = in_entry;
                end
                ST_ONE: begin
                    if (accept && xfer) begin
                        out_d = in_entry;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_entry;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: if (xfer) begin
                    state_d = ST_ONE;
                    out_d   = skid_q;
                end
                default: state_d = ST_EMPTY;
            endcase
            if (accept)
                cnt_d = (cnt_sum > CNT_SAT) ? CNT_SAT[CW-1:0] : cnt_sum[CW-1:0];
        end
        ready_d = (state_d != ST_FULL);
        valid_d = (state_d != ST_EMPTY);
    end

    // State and registered handshake outputs; reset discards both entries
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [L*W-1:0] out_instr;

    // Split the OUT entry onto the output buses
    always_comb begin
        valid_o                  = valid_q;
        ready_o                  = ready_q;
        invalidCount_o           = cnt_q;
        laneValid_o              = out_q[ENTRY_W-1 -: L];
        out_instr                = out_q[L*F+L*A +: L*W];
        address_o                = out_q[L*F +: L*A];
        instructionFormatClass_o = out_q[0 +: L*F];
        opCode_o                 = '0;
        payload_o                = '0;
        for (int unsigned k = 0; k < L; k++) begin
            opCode_o[k*O +: O]  = out_instr[k*W+P +: O];
            payload_o[k*P +: P] = out_instr[k*W +: P];
        end
    end

endmodule

// File: tb/tb_format_class_decode_pipe.sv
// Directed, table-driven bench for format_class_decode_pipe (default parameters).
// Expected classes for refinement-sensitive opcodes follow FMT_REFINE_EN.
module tb_format_class_decode_pipe;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         vin;
    logic         rdy_out;
    logic [1:0]   lv_in;
    logic [63:0]  instr_in;
    logic [63:0]  addr_in;
    logic         vout;
    logic         rdy_in;
    logic [1:0]   lv_out;
    logic [11:0]  op_out;
    logic [51:0]  pay_out;
    logic [127:0] addr_out;
    logic [9:0]   cls_out;
    logic [15:0]  cnt_out;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef FMT_REFINE_EN
    localparam logic [4:0] EXP_V0    = 5'd19;
    localparam logic [4:0] EXP_19B   = 5'd18;
    localparam logic [4:0] EXP_MFSPR = 5'd17;
`else
    localparam logic [4:0] EXP_V0    = 5'd15;
    localparam logic [4:0] EXP_19B   = 5'd6;
    localparam logic [4:0] EXP_MFSPR = 5'd15;
`endif

    format_class_decode_pipe #(
        .instructionWidth(32),
        .addressSize(64),
        .opcodeWidth(6),
        .formatIndexRange(5),
        .laneCount(2),
        .countWidth(16)
    ) dut (
        .clock_i(clk),
        .reset_ni(rst_n),
        .flush_i(flush),
        .valid_i(vin),
        .ready_o(rdy_out),
        .laneValid_i(lv_in),
        .instruction_i(instr_in),
        .address_i(addr_in),
        .valid_o(vout),
        .ready_i(rdy_in),
        .laneValid_o(lv_out),
        .opCode_o(op_out),
        .payload_o(pay_out),
        .address_o(addr_out),
        .instructionFormatClass_o(cls_out),
        .invalidCount_o(cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  lv;
        logic [63:0] addr;
        logic [4:0]  c0;
        logic [4:0]  c1;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] lv, input logic [63:0] ad);
        vin      = v;
        instr_in = {i0, i1};
        lv_in    = lv;
        addr_in  = ad;
    endtask

    task automatic check_bundle(input string tag, input logic [31:0] i0, input logic [31:0] i1,
                                input logic [1:0] lv, input logic [63:0] ad,
                                input logic [4:0] c0, input logic [4:0] c1);
        logic [63:0] ad1;
        ad1 = ad + 64'd4;
        chk({tag, ".valid"}, vout, 1'b1);
        chk({tag, ".lv"},    lv_out, lv);
        chk({tag, ".op0"},   op_out[11:6], i0[31:26]);
        chk({tag, ".op1"},   op_out[5:0], i1[31:26]);
        chk({tag, ".pay0"},  pay_out[51:26], i0[25:0]);
        chk({tag, ".pay1"},  pay_out[25:0], i1[25:0]);
        chk({tag, ".addr0"}, addr_out[127:64], ad);
        chk({tag, ".addr1"}, addr_out[63:0], ad1);
        chk({tag, ".cls0"},  cls_out[9:5], c0);
        chk({tag, ".cls1"},  cls_out[4:0], c1);
    endtask

    initial begin
        logic [15:0] exp_cnt;
        int          guard;

        tbl[0] = '{32'h7C221A14, 32'h38600001, 2'b11, 64'h1000,                5'(EXP_V0),    5'd3, 16'd0};
        tbl[1] = '{32'hE8000000, 32'hE0000000, 2'b11, 64'hFFFF_FFFF_FFFF_FFFC, 5'd5,          5'd4, 16'd0};
        tbl[2] = '{32'h78000000, 32'h50000000, 2'b11, 64'h2_0000_0000,         5'd9,          5'd8, 16'd0};
        tbl[3] = '{32'h10000000, 32'h04000000, 2'b11, 64'h40,                  5'd12,         5'd0, 16'd1};
        tbl[4] = '{32'h4C000004, 32'h4C000020, 2'b11, 64'h80,                  5'd6,  5'(EXP_19B),  16'd1};
        tbl[5] = '{32'hFC000000, 32'hF8000000, 2'b10, 64'hC0,                  5'd0,          5'd5, 16'd2};
        tbl[6] = '{32'hBC000000, 32'hC0000000, 2'b11, 64'h100,                 5'd3,          5'd0, 16'd3};
        tbl[7] = '{32'h24000000, 32'h5C000000, 2'b01, 64'h140,                 5'd0,          5'd8, 16'd3};
        tbl[8] = '{32'h7C0002A6, 32'h58000000, 2'b00, 64'h180,                 5'(EXP_MFSPR), 5'd0, 16'd3};
        tbl[9] = '{32'h7C000000, 32'h08000000, 2'b11, 64'h1C0,                 5'd15,         5'd3, 16'd3};

        // Reset state, with a live-looking input that must be ignored
        rst_n  = 1'b0;
        flush  = 1'b0;
        rdy_in = 1'b1;
        drive(1'b1, 32'h38000000, 32'h38000000, 2'b11, 64'h1234);
        #12;
        chk("rst.valid", vout, 1'b0);
        chk("rst.ready", rdy_out, 1'b0);
        chk("rst.lv",    lv_out, 2'b00);
        chk("rst.op",    op_out, 12'h0);
        chk("rst.pay",   pay_out, 52'h0);
        chk("rst.addr0", addr_out[127:64], 64'h0);
        chk("rst.addr1", addr_out[63:0], 64'h0);
        chk("rst.cls",   cls_out, 10'h0);
        chk("rst.cnt",   cnt_out, 16'h0);
        vin   = 1'b0;
        rst_n = 1'b1;
        chk("rel.ready_before_edge", rdy_out, 1'b0);
        tick();
        chk("rel.ready", rdy_out, 1'b1);
        chk("rel.valid", vout, 1'b0);

        // Streaming with ready_i=1: one bundle per cycle, one-cycle latency
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].i0, tbl[i].i1, tbl[i].lv, tbl[i].addr);
            tick();
            check_bundle($sformatf("vec%0d", i), tbl[i].i0, tbl[i].i1, tbl[i].lv,
                         tbl[i].addr, tbl[i].c0, tbl[i].c1);
            chk($sformatf("vec%0d.cnt", i), cnt_out, tbl[i].cnt);
            chk($sformatf("vec%0d.ready", i), rdy_out, 1'b1);
        end
        vin = 1'b0;
        tick();
        chk("drain.valid", vout, 1'b0);

        // Invalid count: lane 0 opcode 1 valid, lane 1 opcode 1 not valid
        exp_cnt = 16'd3;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h04000000, 32'h04000000, 2'b10, 64'h500);
            tick();
            exp_cnt = exp_cnt + 16'd1;
            chk($sformatf("inv%0d.cnt", i), cnt_out, exp_cnt);
            chk($sformatf("inv%0d.cls", i), cls_out, 10'h0);
        end
        vin = 1'b0;
        tick();
        chk("inv.drain", vout, 1'b0);

        // Back-pressure: A to OUT, B to SKID, C refused until room appears
        rdy_in = 1'b0;
        drive(1'b1, 32'h38000000, 32'h38000000, 2'b11, 64'h2000);
        tick();
        check_bundle("bpA", 32'h38000000, 32'h38000000, 2'b11, 64'h2000, 5'd3, 5'd3);
        chk("bpA.ready", rdy_out, 1'b1);
        drive(1'b1, 32'h78000000, 32'h38000000, 2'b11, 64'h3000);
        tick();
        chk("bpB.ready", rdy_out, 1'b0);
        check_bundle("bpB.holdA", 32'h38000000, 32'h38000000, 2'b11, 64'h2000, 5'd3, 5'd3);
        drive(1'b1, 32'h10000000, 32'h38000000, 2'b11, 64'h4000);
        tick();
        chk("bpC.ready", rdy_out, 1'b0);
        check_bundle("bpC.holdA", 32'h38000000, 32'h38000000, 2'b11, 64'h2000, 5'd3, 5'd3);
        rdy_in = 1'b1;
        tick();
        check_bundle("bpOutB", 32'h78000000, 32'h38000000, 2'b11, 64'h3000, 5'd9, 5'd3);
        chk("bpOutB.ready", rdy_out, 1'b1);
        tick();
        check_bundle("bpOutC", 32'h10000000, 32'h38000000, 2'b11, 64'h4000, 5'd12, 5'd3);
        vin = 1'b0;
        tick();
        chk("bp.drain", vout, 1'b0);
        chk("bp.cnt", cnt_out, exp_cnt);

        // Flush from FULL with a valid (invalid-opcode) input in the same cycle
        rdy_in = 1'b0;
        drive(1'b1, 32'h38000000, 32'h38000000, 2'b11, 64'h6000);
        tick();
        drive(1'b1, 32'h38000000, 32'h38000000, 2'b11, 64'h7000);
        tick();
        chk("flF.full_ready", rdy_out, 1'b0);
        drive(1'b1, 32'h04000000, 32'h04000000, 2'b11, 64'h8000);
        flush = 1'b1;
        tick();
        chk("flF.valid", vout, 1'b0);
        chk("flF.ready", rdy_out, 1'b1);
        chk("flF.cnt",   cnt_out, exp_cnt);
        flush  = 1'b0;
        vin    = 1'b0;
        rdy_in = 1'b1;
        tick();
        chk("flF.dropped", vout, 1'b0);

        // Flush from ONE with an acceptable input: the input must be dropped
        rdy_in = 1'b0;
        drive(1'b1, 32'h38000000, 32'h38000000, 2'b11, 64'h9000);
        tick();
        chk("flO.one", vout, 1'b1);
        drive(1'b1, 32'h04000000, 32'h04000000, 2'b11, 64'hA000);
        flush = 1'b1;
        tick();
        chk("flO.valid", vout, 1'b0);
        chk("flO.ready", rdy_out, 1'b1);
        chk("flO.cnt",   cnt_out, exp_cnt);
        flush  = 1'b0;
        vin    = 1'b0;
        rdy_in = 1'b1;
        tick();
        chk("flO.dropped", vout, 1'b0);

        // Saturation: two INVALID lanes per bundle up to 0xFFFE, then overflow
        rdy_in = 1'b1;
        drive(1'b1, 32'h04000000, 32'h04000000, 2'b11, 64'hB000);
        guard = 0;
        while (exp_cnt < 16'hFFFE && guard < 40000) begin
            tick();
            exp_cnt = exp_cnt + 16'd2;
            guard++;
        end
        chk("sat.guard", (guard < 40000) ? 1'b1 : 1'b0, 1'b1);
        chk("sat.pre",   cnt_out, 16'hFFFE);
        tick();
        chk("sat.hit",   cnt_out, 16'hFFFF);
        tick();
        chk("sat.hold",  cnt_out, 16'hFFFF);

        // Reset asserted mid-transfer while FULL discards both entries
        rdy_in = 1'b0;
        tick();
        tick();
        chk("mid.full_ready", rdy_out, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.valid", vout, 1'b0);
        chk("mid.ready", rdy_out, 1'b0);
        chk("mid.cnt",   cnt_out, 16'h0);
        chk("mid.cls",   cls_out, 10'h0);
        chk("mid.addr0", addr_out[127:64], 64'h0);
        vin    = 1'b0;
        rdy_in = 1'b1;
        #3;
        rst_n = 1'b1;
        tick();
        chk("mid.rel_ready", rdy_out, 1'b1);
        chk("mid.rel_valid", vout, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
